// File: rtl/dram_arbiter_pkg.sv
// Shared types for the DRAM port arbiter:
// FSM state encoding and requester port indices.
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam logic ARB_P0 = 1'b0;
  localparam logic ARB_P1 = 1'b1;

endpackage

// File: rtl/dram_arbiter_rr_pick2.sv
// Two-way round-robin picker with optional
// hard priority for port 0.
module dram_arbiter_rr_pick2
  import dram_arbiter_pkg::*;
(
  input  logic oe0,
  input  logic oe1,
  input  logic prio0,
  input  logic rr_ptr,
  output logic gnt,
  output logic any
);

  // winner select: prio, lone requester, then pointer
  always_comb begin
    any = oe0 | oe1;
    gnt = ARB_P0;
    if (prio0 && oe0)
      gnt = ARB_P0;
    else if (oe0 && !oe1)
      gnt = ARB_P0;
    else if (oe1 && !oe0)
      gnt = ARB_P1;
    else if (oe0 && oe1)
      gnt = rr_ptr;
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one DRAM controller port between the loader
// and the CPU data side; one access in flight.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            prio0,
  input  logic            m0_oe,
  input  logic [DW/8-1:0] m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_valid,
  input  logic            m1_oe,
  input  logic [DW/8-1:0] m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_valid,
  output logic            dram_oe,
  output logic [DW/8-1:0] dram_we,
  output logic [AW-1:0]   dram_addr,
  output logic [DW-1:0]   dram_wdata,
  input  logic            dram_ready,
  input  logic [DW-1:0]   dram_rdata,
  input  logic            dram_valid,
  output logic            timeout_err
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);
  localparam bit WD_ON = (TIMEOUT > 0);

  arb_state_e    state_q, state_d;
  logic          gnt, any;
  logic          gnt_q, rr_q, err_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] r0_q, r1_q, rdata_d;
  logic          load, go, fin, abort, done;

  dram_arbiter_rr_pick2 u_pick (
    .oe0    (m0_oe),
    .oe1    (m1_oe),
    .prio0  (prio0),
    .rr_ptr (rr_q),
    .gnt    (gnt),
    .any    (any)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  // next state, command strobe and completion
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    go      = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
    dram_oe = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any) begin
          load    = 1'b1;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        dram_oe = 1'b1;
        if (dram_ready) begin
          go      = 1'b1;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (dram_valid)
          fin = 1'b1;
        else if (WD_ON && cnt_q >= CMAX)
          abort = 1'b1;
        if (fin || abort)
          state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    done     = fin | abort;
    rdata_d  = fin ? dram_rdata : '0;
    m0_valid = done && (gnt_q == ARB_P0);
    m1_valid = done && (gnt_q == ARB_P1);
    m0_rdata = m0_valid ? rdata_d : r0_q;
    m1_rdata = m1_valid ? rdata_d : r1_q;
  end

  // latch the winning command at arbitration
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= ARB_P0;
      dram_we    <= '0;
      dram_addr  <= '0;
      dram_wdata <= '0;
    end else if (load) begin
      gnt_q      <= gnt;
      dram_we    <= gnt ? m1_we    : m0_we;
      dram_addr  <= gnt ? m1_addr  : m0_addr;
      dram_wdata <= gnt ? m1_wdata : m0_wdata;
    end
  end

  // watchdog: counts from the accepted strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (go)
        cnt_q <= CW'(1);
      else if (state_q == ARB_WAIT && cnt_q < CMAX)
        cnt_q <= cnt_q + CW'(1);
      if (abort)
        err_q <= 1'b1;
    end
  end

  // hold read data per port, advance rr pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= ARB_P0;
      r0_q <= '0;
      r1_q <= '0;
    end else if (done) begin
      rr_q <= ~gnt_q;
      if (gnt_q == ARB_P0) r0_q <= rdata_d;
      else                 r1_q <= rdata_d;
    end
  end

  assign timeout_err = err_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter:
// arbitration, stalls, watchdog and reset.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        prio0;
  logic        m0_oe, m1_oe;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_valid, m1_valid;
  logic        dram_oe;
  logic [3:0]  dram_we;
  logic [31:0] dram_addr, dram_wdata;
  logic        dram_ready;
  logic [31:0] dram_rdata;
  logic        dram_valid;
  logic        timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  dram_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .prio0       (prio0),
    .m0_oe       (m0_oe),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_rdata    (m0_rdata),
    .m0_valid    (m0_valid),
    .m1_oe       (m1_oe),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_rdata    (m1_rdata),
    .m1_valid    (m1_valid),
    .dram_oe     (dram_oe),
    .dram_we     (dram_we),
    .dram_addr   (dram_addr),
    .dram_wdata  (dram_wdata),
    .dram_ready  (dram_ready),
    .dram_rdata  (dram_rdata),
    .dram_valid  (dram_valid),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // step one cycle; dram_valid is a pulse
  task automatic tick();
    @(posedge clk);
    #1;
    dram_valid = 1'b0;
  endtask

  // wait for accepted strobe, answer after lat
  task automatic serve(input int lat,
                       input logic [31:0] data,
                       output int port,
                       output logic [31:0] addr,
                       output logic [31:0] rd);
    int k;
    k = 0;
    while (!(dram_oe && dram_ready) && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) check("oe_wait", 1, 0);
    addr = dram_addr;
    tick();
    repeat (lat - 1) tick();
    dram_valid = 1'b1;
    dram_rdata = data;
    #1;
    port = m1_valid ? 1 : (m0_valid ? 0 : -1);
    rd   = m1_valid ? m1_rdata : m0_rdata;
    if (m0_valid && m1_valid) port = -2;
  endtask

  initial begin
    int p, c0, c1, k;
    logic [31:0] a, r;
    int exp_p[4] = '{0, 1, 0, 1};

    rst = 1'b1; prio0 = 1'b0;
    m0_oe = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_oe = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    dram_ready = 1'b1; dram_rdata = 0; dram_valid = 0;
    tick(); tick();
    rst = 1'b0;
    check("rst_oe",    dram_oe, 0);
    check("rst_v0",    m0_valid, 0);
    check("rst_v1",    m1_valid, 0);
    check("rst_err",   timeout_err, 0);
    check("rst_addr",  dram_addr, 0);

    // 1: single m1 read
    m1_oe = 1; m1_addr = 32'h100;
    #1 check("t1_oe_n", dram_oe, 0);
    tick();
    check("t1_oe_n1", dram_oe, 1);
    check("t1_we", dram_we, 0);
    serve(5, 32'hdeadbeef, p, a, r);
    check("t1_port", p, 1);
    check("t1_addr", a, 32'h100);
    check("t1_rd", r, 32'hdeadbeef);
    m1_oe = 0;
    tick();
    check("t1_v_end", m1_valid, 0);
    tick();
    check("t1_idle", dram_oe, 0);

    // 2: both request, round robin
    m0_addr = 32'h200; m1_addr = 32'h300;
    m0_oe = 1; m1_oe = 1;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 4; i++) begin
      serve(2, 32'h1000 + i, p, a, r);
      check("t2_port", p, exp_p[i]);
      check("t2_addr", a, exp_p[i] ? 32'h300 : 32'h200);
      check("t2_rd", r, 32'h1000 + i);
      if (p == 0) c0++;
      if (p == 1) c1++;
    end
    check("t2_cnt0", c0, 2);
    check("t2_cnt1", c1, 2);

    // 3: prio0 holds port 0
    prio0 = 1;
    for (int i = 0; i < 3; i++) begin
      serve(1, 32'h2000 + i, p, a, r);
      check("t3_prio", p, 0);
    end
    prio0 = 0;
    serve(1, 32'h3000, p, a, r);
    check("t3_after", p, 1);
    check("t3_rd1", m1_rdata, 32'h3000);
    m0_oe = 0; m1_oe = 0;
    tick(); tick();

    // 4: write with ready stall
    m0_oe = 1; m0_we = 4'b0011;
    m0_addr = 32'h8; m0_wdata = 32'h1234;
    dram_ready = 0;
    tick();
    k = 0;
    for (int i = 0; i < 3; i++) begin
      if (dram_oe) k++;
      check("t4_hold", {dram_we, dram_addr[15:0],
            dram_wdata[15:0]}, {4'b0011, 16'h8, 16'h1234});
      tick();
    end
    m0_oe = 0; m0_addr = 0; m0_wdata = 0; m0_we = 0;
    dram_ready = 1;
    #1;
    if (dram_oe) k++;
    check("t4_oe_cyc", k, 4);
    check("t4_addr", dram_addr, 32'h8);
    tick();
    check("t4_oe_off", dram_oe, 0);
    dram_valid = 1; dram_rdata = 0;
    #1 check("t4_v0", m0_valid, 1);
    tick();

    // 5: watchdog abort
    m1_oe = 1; m1_addr = 32'h40;
    tick();
    check("t5_oe", dram_oe, 1);
    m1_oe = 0;
    k = 0;
    tick(); k++;
    while (!m1_valid && k < 40) begin
      tick(); k++;
    end
    check("t5_lat", k, 16);
    check("t5_rd0", m1_rdata, 0);
    check("t5_err_pre", timeout_err, 0);
    tick();
    check("t5_err", timeout_err, 1);
    dram_valid = 1; dram_rdata = 32'h5555;
    #1;
    check("t5_late", {m0_valid, m1_valid}, 0);
    tick();

    // 6: reset mid-transaction
    m1_oe = 1; m1_addr = 32'h44;
    tick(); tick();
    m1_oe = 0;
    rst = 1;
    tick();
    check("t6_oe", dram_oe, 0);
    check("t6_addr", dram_addr, 0);
    check("t6_err", timeout_err, 0);
    check("t6_rd1", m1_rdata, 0);
    rst = 0;
    dram_valid = 1; dram_rdata = 32'h7777;
    #1;
    check("t6_late", {m0_valid, m1_valid}, 0);
    tick();
    m0_oe = 1; m1_oe = 1;
    m0_addr = 32'h500; m1_addr = 32'h600;
    tick();
    check("t6_oe2", dram_oe, 1);
    check("t6_gnt0", dram_addr, 32'h500);
    m0_oe = 0; m1_oe = 0;
    serve(1, 32'h9, p, a, r);
    check("t6_port", p, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
